// File: rtl/gcd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_arbiter_pkg
// Purpose  : Shared widths, requester count and FSM state type for gcd_arbiter.
// Revision : 1.0
// ============================================================================
package gcd_arbiter_pkg;

    localparam int REQ_W   = 32;
    localparam int RESP_W  = 16;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : gcd_arbiter_rr
// Purpose  : Two-way round-robin grant; pointer moves to the loser on accept.
// Revision : 1.0
// ============================================================================
module gcd_arbiter_rr
    import gcd_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic               o_grant_id,
    output logic               o_grant_any
);

    logic r_ptr;

    always_comb begin
        o_grant_any = |i_req;
        if (&i_req) begin
            o_grant_id = r_ptr;
        end else begin
            o_grant_id = i_req[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~o_grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gcd_arbiter
// Purpose  : Shares one GCD unit between two requesters, one transaction at a
//            time. Define GCD_ARBITER_PERF_EN to build the performance counters.
// Revision : 1.0
// ============================================================================
module gcd_arbiter
    import gcd_arbiter_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              r0_req_val,
    output logic              r0_req_rdy,
    input  logic [REQ_W-1:0]  r0_req_msg,
    output logic              r0_resp_val,
    input  logic              r0_resp_rdy,
    output logic [RESP_W-1:0] r0_resp_msg,
    input  logic              r1_req_val,
    output logic              r1_req_rdy,
    input  logic [REQ_W-1:0]  r1_req_msg,
    output logic              r1_resp_val,
    input  logic              r1_resp_rdy,
    output logic [RESP_W-1:0] r1_resp_msg,
    output logic              gcd_req_val,
    input  logic              gcd_req_rdy,
    output logic [REQ_W-1:0]  gcd_req_msg,
    input  logic              gcd_resp_val,
    output logic              gcd_resp_rdy,
    input  logic [RESP_W-1:0] gcd_resp_msg,
    output logic              busy_o,
    output logic              owner_o,
    output logic              err_o,
    output logic [15:0]       op_count_o,
    output logic [31:0]       busy_cycles_o
);

    state_t              r_state;
    logic                r_owner;
    logic [REQ_W-1:0]    r_req_msg;
    logic [RESP_W-1:0]   r_resp_msg;
    logic [15:0]         r_wait_cnt;
    logic                r_err;

    logic                w_idle;
    logic                w_waiting;
    logic                w_grant_id;
    logic                w_grant_any;
    logic                w_accept;
    logic                w_resp_fire;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_waiting = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    // Gated by reset so no ready can leak out while reset is held.
    assign w_accept  = w_idle && w_grant_any && wb_rst_ni;

    gcd_arbiter_rr u_rr (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_ni),
        .i_req       ({r1_req_val, r0_req_val}),
        .i_accept    (w_accept),
        .o_grant_id  (w_grant_id),
        .o_grant_any (w_grant_any)
    );

    assign r0_req_rdy  = w_accept && !w_grant_id;
    assign r1_req_rdy  = w_accept &&  w_grant_id;
    assign w_resp_fire = (r_state == ST_RESP) && (r_owner ? r1_resp_rdy : r0_resp_rdy);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_req_msg  <= '0;
            r_resp_msg <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner   <= w_grant_id;
                        r_req_msg <= w_grant_id ? r1_req_msg : r0_req_msg;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (gcd_req_rdy) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (gcd_resp_val) begin
                        r_resp_msg <= gcd_resp_msg;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_resp_fire) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gcd_req_val  = (r_state == ST_ISSUE);
    assign gcd_req_msg  = r_req_msg;
    assign gcd_resp_rdy = (r_state == ST_WAIT);
    assign r0_resp_val  = (r_state == ST_RESP) && !r_owner;
    assign r1_resp_val  = (r_state == ST_RESP) &&  r_owner;
    assign r0_resp_msg  = r_resp_msg;
    assign r1_resp_msg  = r_resp_msg;
    assign busy_o       = !w_idle;
    assign owner_o      = r_owner;
    assign err_o        = r_err;

    // Watchdog only flags a slow GCD unit; the transaction keeps waiting.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if (w_waiting && (r_wait_cnt != TIMEOUT_CYCLES)) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
            if ((r_wait_cnt + 16'd1) == TIMEOUT_CYCLES) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef GCD_ARBITER_PERF_EN
    logic [15:0] r_op_count;
    logic [31:0] r_busy_cycles;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_op_count    <= '0;
            r_busy_cycles <= '0;
        end else begin
            if (w_resp_fire) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if (!w_idle) begin
                r_busy_cycles <= r_busy_cycles + 32'd1;
            end
        end
    end

    assign op_count_o    = r_op_count;
    assign busy_cycles_o = r_busy_cycles;
`else
    assign op_count_o    = '0;
    assign busy_cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_arbiter
// Purpose  : Scoreboard bench for gcd_arbiter with a behavioural GCD unit.
// Revision : 1.0
// ============================================================================
module tb_gcd_arbiter;

    logic        clk = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic [1:0]  d_val;
    logic [31:0] d_msg [2];
    logic [1:0]  d_resp_rdy;
    logic        r0_req_rdy, r1_req_rdy, r0_resp_val, r1_resp_val;
    logic [15:0] r0_resp_msg, r1_resp_msg;
    logic        gcd_req_val, gcd_req_rdy, gcd_resp_val, gcd_resp_rdy;
    logic [31:0] gcd_req_msg;
    logic [15:0] gcd_resp_msg;
    logic        busy_o, owner_o, err_o;
    logic [15:0] op_count_o;
    logic [31:0] busy_cycles_o;

    gcd_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni),
        .r0_req_val(d_val[0]), .r0_req_rdy(r0_req_rdy), .r0_req_msg(d_msg[0]),
        .r0_resp_val(r0_resp_val), .r0_resp_rdy(d_resp_rdy[0]), .r0_resp_msg(r0_resp_msg),
        .r1_req_val(d_val[1]), .r1_req_rdy(r1_req_rdy), .r1_req_msg(d_msg[1]),
        .r1_resp_val(r1_resp_val), .r1_resp_rdy(d_resp_rdy[1]), .r1_resp_msg(r1_resp_msg),
        .gcd_req_val(gcd_req_val), .gcd_req_rdy(gcd_req_rdy), .gcd_req_msg(gcd_req_msg),
        .gcd_resp_val(gcd_resp_val), .gcd_resp_rdy(gcd_resp_rdy), .gcd_resp_msg(gcd_resp_msg),
        .busy_o(busy_o), .owner_o(owner_o), .err_o(err_o),
        .op_count_o(op_count_o), .busy_cycles_o(busy_cycles_o)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Stimulus controls and reference-model state
    logic        drv_en = 1'b0, gaps = 1'b0, gcd_hold = 1'b0;
    logic [1:0]  hold_rdy = 2'b00;
    logic [31:0] pend [2][$];
    logic [15:0] exp_q [2][$];
    logic [31:0] gmsg_q[$];
    logic        grant_log[$];
    logic        m_ptr = 1'b0, m_busy = 1'b0, m_owner = 1'b0;
    logic        m_issued = 1'b0, m_wait = 1'b0, m_resp = 1'b0;
    int          acc_edge = 0, m_ops = 0, m_busy_cyc = 0;
    int          n_done [2];
    logic [15:0] last_resp [2];
    logic [1:0]  hs_req = 2'b00;
    logic        hs_gcd_req = 1'b0, hs_gcd_resp = 1'b0;
    logic [31:0] gcd_cap = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] gcd16(input logic [31:0] m);
        logic [15:0] a, b, t;
        a = m[31:16];
        b = m[15:0];
        while (b != 16'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'd0;
            1:       return 16'($urandom_range(1, 15));
            default: return 16'($urandom_range(0, 16'hFFFF));
        endcase
    endfunction

    // Requester drivers
    initial begin
        logic dropped;
        d_val = 2'b00; d_msg[0] = '0; d_msg[1] = '0; d_resp_rdy = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (drv_en) begin
                for (int x = 0; x < 2; x++) begin
                    dropped = 1'b0;
                    if (d_val[x] && hs_req[x]) begin
                        void'(pend[x].pop_front());
                        d_val[x] = 1'b0;
                    end else if (d_val[x] && gaps && $urandom_range(0, 7) == 0) begin
                        d_val[x] = 1'b0;
                        dropped = 1'b1;
                    end
                    if (!d_val[x] && !dropped && pend[x].size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
                        d_val[x] = 1'b1;
                        d_msg[x] = pend[x][0];
                    end
                    if (!d_val[x]) d_msg[x] = $urandom;
                    d_resp_rdy[x] = hold_rdy[x] ? 1'b0 : (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
                end
            end
        end
    end

    // Behavioural GCD unit
    initial begin
        logic        g_busy;
        int          g_cnt, g_stall;
        logic [15:0] g_res;
        g_busy = 0; g_cnt = 0; g_stall = 0; g_res = '0;
        gcd_req_rdy = 0; gcd_resp_val = 0; gcd_resp_msg = '0;
        forever begin
            @(posedge clk); #1;
            if (!wb_rst_ni) begin
                gcd_req_rdy = 0; gcd_resp_val = 0; g_busy = 0; g_stall = 0;
            end else begin
                if (hs_gcd_req) begin
                    gcd_req_rdy = 0; g_busy = 1; g_stall = 0;
                    g_res = gcd16(gcd_cap);
                    g_cnt = $urandom_range(0, 1);
                end else if (!g_busy) begin
                    if (gcd_req_val) begin
                        gcd_req_rdy = (g_stall >= 1) || ($urandom_range(0, 1) == 1);
                        g_stall++;
                    end else begin
                        gcd_req_rdy = 0; g_stall = 0;
                    end
                end
                if (hs_gcd_resp) begin
                    gcd_resp_val = 0; g_busy = 0;
                end else if (g_busy && !gcd_resp_val) begin
                    if (g_cnt > 0) g_cnt--;
                    else if (!gcd_hold) begin
                        gcd_resp_val = 1; gcd_resp_msg = g_res;
                    end
                end
                if (!gcd_resp_val) gcd_resp_msg = 16'($urandom_range(0, 16'hFFFF));
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        g, st_prev;
        logic [1:0]  exp_rdy, exp_rv;
        logic [31:0] st_msg;
        st_prev = 0; st_msg = '0;
        forever begin
            @(negedge clk);
            if (!wb_rst_ni) begin
                hs_req = 0; hs_gcd_req = 0; hs_gcd_resp = 0; st_prev = 0;
                continue;
            end
            exp_rdy = 2'b00;
            if (!m_busy && d_val != 2'b00) begin
                g = (d_val == 2'b11) ? m_ptr : d_val[1];
                exp_rdy = g ? 2'b10 : 2'b01;
            end
            check("req_rdy", {30'd0, r1_req_rdy, r0_req_rdy}, {30'd0, exp_rdy});
            check("busy", {31'd0, busy_o}, {31'd0, m_busy});
            if (m_busy) check("owner", {31'd0, owner_o}, {31'd0, m_owner});
            check("gcd_req_val", {31'd0, gcd_req_val}, {31'd0, m_busy && !m_issued});
            check("gcd_resp_rdy", {31'd0, gcd_resp_rdy}, {31'd0, m_wait});
            exp_rv = (m_busy && m_resp) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            check("resp_val", {30'd0, r1_resp_val, r0_resp_val}, {30'd0, exp_rv});
            if (st_prev) check("gcd_req_hold", {gcd_req_val, gcd_req_msg[30:0]}, {1'b1, st_msg[30:0]});

            hs_req = d_val & {r1_req_rdy, r0_req_rdy};
            if (hs_req != 2'b00) begin
                g = hs_req[1];
                exp_q[g].push_back(gcd16(d_msg[g]));
                gmsg_q.push_back(d_msg[g]);
                grant_log.push_back(g);
                m_ptr = ~g; m_busy = 1; m_owner = g;
                m_issued = 0; m_wait = 0; m_resp = 0;
                acc_edge = cyc + 1;
            end
            hs_gcd_req = gcd_req_val && gcd_req_rdy;
            if (hs_gcd_req) begin
                check("gcd_msg_expected", {31'd0, gmsg_q.size() > 0}, 32'd1);
                if (gmsg_q.size() > 0) check("gcd_req_msg", gcd_req_msg, gmsg_q.pop_front());
                gcd_cap = gcd_req_msg;
                m_issued = 1; m_wait = 1;
            end
            st_prev = gcd_req_val && !gcd_req_rdy;
            st_msg  = gcd_req_msg;
            hs_gcd_resp = gcd_resp_val && gcd_resp_rdy;
            if (hs_gcd_resp) begin
                m_wait = 0; m_resp = 1;
            end
            for (int x = 0; x < 2; x++) begin
                if ((x == 0 ? r0_resp_val && d_resp_rdy[0] : r1_resp_val && d_resp_rdy[1])) begin
                    check("resp_expected", {31'd0, exp_q[x].size() > 0}, 32'd1);
                    last_resp[x] = (x == 0) ? r0_resp_msg : r1_resp_msg;
                    if (exp_q[x].size() > 0) check("resp_data", {16'd0, last_resp[x]}, {16'd0, exp_q[x].pop_front()});
                    n_done[x]++;
                    m_ops++;
                    m_busy_cyc += cyc + 1 - acc_edge;
                    m_busy = 0; m_resp = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        drv_en = 0; wb_rst_ni = 0;
        d_val = 2'b11; d_resp_rdy = 2'b11;
        for (int x = 0; x < 2; x++) begin
            pend[x].delete(); exp_q[x].delete();
            n_done[x] = 0; last_resp[x] = 16'hDEAD;
        end
        gmsg_q.delete(); grant_log.delete();
        m_ptr = 0; m_busy = 0; m_owner = 0; m_issued = 0; m_wait = 0; m_resp = 0;
        m_ops = 0; m_busy_cyc = 0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {23'd0, r0_req_rdy, r1_req_rdy, r0_resp_val, r1_resp_val,
                              gcd_req_val, gcd_resp_rdy, busy_o, owner_o, err_o}, 32'd0);
        check("rst_op_count", {16'd0, op_count_o}, 32'd0);
        check("rst_busy_cycles", busy_cycles_o, 32'd0);
        @(posedge clk); #2;
        d_val = 2'b00; d_resp_rdy = 2'b00; wb_rst_ni = 1;
        @(posedge clk); #2;
        drv_en = 1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((pend[0].size() > 0 || pend[1].size() > 0 || m_busy || d_val != 2'b00) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {31'd0, n < budget}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cond_timeout(input string name, input int sel, input int budget);
        int n = 0;
        while (n < budget && !((sel == 0 && m_busy) || (sel == 1 && r0_resp_val) || (sel == 2 && gcd_resp_rdy))) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, n < budget}, 32'd1);
    endtask

    task automatic check_perf();
`ifdef GCD_ARBITER_PERF_EN
        check("op_count", {16'd0, op_count_o}, {16'd0, m_ops[15:0]});
        check("busy_cycles", busy_cycles_o, m_busy_cyc);
`else
        check("op_count_tied", {16'd0, op_count_o}, 32'd0);
        check("busy_cycles_tied", busy_cycles_o, 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        do_reset();

        // Single r0 request
        pend[0].push_back(32'h000F_0005);
        wait_drain(200);
        check("r0_single", {16'd0, last_resp[0]}, 32'h0005);
        check("r1_no_resp", n_done[1], 0);
        check_perf();

        // Simultaneous requests from reset: r0 first
        do_reset();
        pend[0].push_back(32'h0030_0012);
        pend[1].push_back(32'h0015_0007);
        wait_drain(200);
        check("grant_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("first_grant", {31'd0, grant_log[0]}, 32'd0);
            check("second_grant", {31'd0, grant_log[1]}, 32'd1);
        end
        check("r0_gcd", {16'd0, last_resp[0]}, 32'h0006);
        check("r1_gcd", {16'd0, last_resp[1]}, 32'h0007);

        // Continuous contention alternates grants
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pend[0].push_back({rand_op(), rand_op()});
            pend[1].push_back({rand_op(), rand_op()});
        end
        wait_drain(500);
        check("alt_count", grant_log.size(), 8);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("alternate", {31'd0, grant_log[i]}, i % 2);

        // Owner stalls its response; r1 must stay ungranted
        hold_rdy[0] = 1;
        pend[0].push_back(32'h0048_0030);
        wait_cond_timeout("r0_resp_wait", 1, 100);
        @(posedge clk); #2;
        pend[1].push_back(32'h0009_0006);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_resp_val", {31'd0, r0_resp_val}, 32'd1);
            check("hold_resp_msg", {16'd0, r0_resp_msg}, 32'h0018);
            check("hold_r1_rdy", {31'd0, r1_req_rdy}, 32'd0);
        end
        @(posedge clk); #2;
        hold_rdy[0] = 0;
        wait_drain(200);
        check("after_hold_r1", {16'd0, last_resp[1]}, 32'h0003);

        // Randomized traffic
        gaps = 1;
        for (int i = 0; i < 150; i++) begin
            idx = $urandom_range(0, 1);
            pend[idx].push_back({rand_op(), rand_op()});
        end
        wait_drain(20000);
        check_perf();
        check("no_err_random", {31'd0, err_o}, 32'd0);
        gaps = 0;

        // Timeout flag
        @(posedge clk); #2;
        gcd_hold = 1;
        pend[0].push_back(32'h0064_0028);
        wait_cond_timeout("timeout_accept", 0, 50);
        while (cyc < acc_edge + 7) @(negedge clk);
        check("err_before", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        check("err_at_limit", {31'd0, err_o}, 32'd1);
        repeat (4) @(negedge clk);
        check("still_busy", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #2;
        gcd_hold = 0;
        wait_drain(200);
        check("late_resp", {16'd0, last_resp[0]}, 32'h0014);
        check("err_sticky", {31'd0, err_o}, 32'd1);

        // Reset while in WAIT
        @(posedge clk); #2;
        gcd_hold = 1;
        pend[1].push_back(32'h0020_0018);
        wait_cond_timeout("reach_wait", 2, 50);
        do_reset();
        gcd_hold = 0;
        pend[1].push_back(32'h0012_0008);
        wait_drain(200);
        check("post_reset_resp", {16'd0, last_resp[1]}, 32'h0002);
        check("post_reset_done", n_done[1], 1);
        check_perf();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd1024, the maximum cycles a transaction waits on the GCD unit before the error flag is raised.
REQ-002 SHALL have port wb_clk_i  in  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port wb_rst_ni  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports r0_req_val in 1, r0_req_rdy out 1, r0_req_msg in 32: requester 0 (Wishbone) request; {opA[31:16], opB[15:0]}.
REQ-005 SHALL have ports r0_resp_val out 1, r0_resp_rdy in 1, r0_resp_msg out 16: requester 0 response.
REQ-006 SHALL have ports r1_req_val/r1_req_rdy/r1_req_msg and r1_resp_val/r1_resp_rdy/r1_resp_msg: requester 1 (logic analyzer), same widths and directions.
REQ-007 SHALL have ports gcd_req_val out 1, gcd_req_rdy in 1, gcd_req_msg out 32: request to the shared GcdUnit.
REQ-008 SHALL have ports gcd_resp_val in 1, gcd_resp_rdy out 1, gcd_resp_msg in 16: response from the GcdUnit.
REQ-009 SHALL have ports busy_o out 1 (FSM not IDLE), owner_o out 1 (current grantee), err_o out 1 (sticky timeout flag).
REQ-010 SHALL have ports op_count_o out 16 and busy_cycles_o out 32: performance counters.

Function
REQ-011 SHALL use FSM states IDLE, ISSUE, WAIT, RESP, with exactly one transaction outstanding.
REQ-012 SHALL, in IDLE only, assert rX_req_rdy=1 for the granted requester only; when no requester is valid, every rX_req_rdy SHALL be 0.
REQ-013 SHALL grant a lone valid requester; when both are valid, SHALL grant the requester the priority pointer selects.
REQ-014 SHALL flip the priority pointer to the non-granted requester on every accept.
REQ-015 SHALL, on accept (val&&rdy at cycle N), latch the message and owner and go to ISSUE; gcd_req_val SHALL be 1 from N+1.
REQ-016 SHALL, in ISSUE, hold gcd_req_val=1 and a stable gcd_req_msg until gcd_req_rdy=1, then go to WAIT.
REQ-017 SHALL, in WAIT, drive gcd_resp_rdy=1; on gcd_resp_val, SHALL latch gcd_resp_msg and go to RESP. gcd_resp_rdy SHALL be 0 in every other state.
REQ-018 SHALL, in RESP, assert resp_val only to the owner with the latched message; on owner resp_rdy, SHALL go to IDLE, and the next accept SHALL be possible in that IDLE cycle.
REQ-019 SHALL count cycles spent in ISSUE+WAIT; on reaching TIMEOUT_CYCLES, SHALL set err_o, which stays 1 until reset. The FSM SHALL keep waiting; no transaction is aborted.
REQ-020 SHALL ignore a requester dropping val while not granted; no state change results.
REQ-021 SHALL pass operands unmodified, including zero operands, to the GCD unit.

Reset
REQ-022 SHALL, on wb_rst_ni=0 at any time including mid-transaction, go to IDLE, drop any latched transaction, and set pointer=0 (requester 0 first), err_o=0, all counters=0.
REQ-023 SHALL hold all valid/ready outputs, busy_o and owner_o at 0 during reset.

Configuration
REQ-024 SHALL, with macro GCD_ARBITER_PERF_EN defined, increment op_count_o on each RESP completion and busy_cycles_o on each cycle with busy_o=1; both SHALL wrap on overflow.
REQ-025 SHALL, without GCD_ARBITER_PERF_EN, keep both counter ports present, tie them to 0, and synthesize no counter registers.

Structure
REQ-026 SHALL place the FSM state enum, message widths (REQ_W=32, RESP_W=16) and the requester-count constant (2) in package gcd_arbiter_pkg.
REQ-027 SHALL implement the two-way round-robin grant and pointer as sub-module gcd_arbiter_rr.

Verification
REQ-028 SHALL verify that a single r0 request 0x000F_0005 yields r0_resp_msg=0x0005, that r1 sees no resp_val, and that op_count_o=1 when PERF_EN is defined.
REQ-029 SHALL verify that simultaneous r0 0x0030_0012 and r1 0x0015_0007 from reset are served r0 first (0x0006), then r1 (0x0007).
REQ-030 SHALL verify that with both requesters continuously valid for 4 transactions the grants alternate r0,r1,r0,r1.
REQ-031 SHALL verify that r0_resp_rdy held 0 for 10 cycles keeps r0_resp_val=1 with a stable message and keeps r1 ungranted.
REQ-032 SHALL verify that gcd_resp_val withheld with TIMEOUT_CYCLES=8 sets err_o after 8 cycles, and that a late response still completes normally.
REQ-033 SHALL verify that wb_rst_ni asserted in WAIT gives busy_o=0, all valid outputs 0 and err_o=0, and that a subsequent request completes correctly.
